// File: rtl/game_pkg.sv
// Shared game types: direction encoding and move-scheduler FSM states.
package game_pkg;

  localparam int unsigned NUM_KEYS = 4;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DELAY  = 2'd2,
    ST_REPEAT = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: first request at or above ptr (mod 4).
module rr_arbiter4
  import game_pkg::*;
(
  input  logic [NUM_KEYS-1:0] i_req,
  input  logic [1:0]          i_ptr,
  output logic [1:0]          o_grant_c,
  output logic                o_grant_valid_c
);

  logic [1:0] w_idx;

  // Scan offsets from highest to lowest so the nearest request to ptr wins.
  always_comb begin
    o_grant_c       = i_ptr;
    o_grant_valid_c = 1'b0;
    w_idx           = i_ptr;
    for (int k = int'(NUM_KEYS) - 1; k >= 0; k--) begin
      w_idx = i_ptr + 2'(k);
      if (i_req[w_idx]) begin
        o_grant_c       = w_idx;
        o_grant_valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_move_scheduler.sv
// Direction key strobes -> single-step move commands with round-robin
// arbitration and typematic auto-repeat over a valid/ready handshake.
module key_move_scheduler
  import game_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000,
  parameter int unsigned CNT_W         = 25
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic       left_key,
  input  logic       right_key,
  input  logic       up_key,
  input  logic       down_key,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic       move_repeat,
  output logic       busy
);

  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

  logic [NUM_KEYS-1:0] w_keys;
  logic [NUM_KEYS-1:0] r_key_q;
  logic [NUM_KEYS-1:0] r_key_qq;
  logic [NUM_KEYS-1:0] w_rise;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_timer;
  logic [CNT_W-1:0]    w_timer_nxt;
  logic [1:0]          r_rr_ptr;
  logic [1:0]          w_rr_ptr_nxt;
  logic                r_move_valid;
  logic                w_move_valid_nxt;
  dir_t                r_move_dir;
  dir_t                w_move_dir_nxt;
  logic                r_move_repeat;
  logic                w_move_repeat_nxt;
  logic                r_busy;

  logic [1:0]          w_grant;
  logic                w_grant_valid;
  logic                w_active_held;

  assign w_keys        = {down_key, up_key, right_key, left_key};
  assign w_rise        = r_key_q & ~r_key_qq;
  assign w_active_held = r_key_q[r_move_dir];

  rr_arbiter4 u_arb (
    .i_req           (w_rise),
    .i_ptr           (r_rr_ptr),
    .o_grant_c       (w_grant),
    .o_grant_valid_c (w_grant_valid)
  );

  // Key history for rising-edge detection.
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      r_key_q  <= '0;
      r_key_qq <= '0;
    end else begin
      r_key_q  <= w_keys;
      r_key_qq <= r_key_q;
    end
  end

  // Next-state, timer, pointer and output-register values.
  always_comb begin
    w_state_nxt       = r_state;
    w_timer_nxt       = r_timer;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_move_valid_nxt  = r_move_valid;
    w_move_dir_nxt    = r_move_dir;
    w_move_repeat_nxt = r_move_repeat;

    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_state_nxt       = ST_ISSUE;
          w_move_valid_nxt  = 1'b1;
          w_move_dir_nxt    = dir_t'(w_grant);
          w_move_repeat_nxt = 1'b0;
          w_rr_ptr_nxt      = w_grant + 2'd1;
        end
      end

      // Pending command is frozen; new rises here are dropped.
      ST_ISSUE: begin
        if (move_ready) begin
          w_move_valid_nxt = 1'b0;
          if (w_active_held) begin
            w_state_nxt = r_move_repeat ? ST_REPEAT : ST_DELAY;
            w_timer_nxt = r_move_repeat ? PERIOD_LOAD : DELAY_LOAD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end

      // Waiting for repeat: a fresh press pre-empts, release ends the press.
      ST_DELAY, ST_REPEAT: begin
        if (w_grant_valid) begin
          w_state_nxt       = ST_ISSUE;
          w_move_valid_nxt  = 1'b1;
          w_move_dir_nxt    = dir_t'(w_grant);
          w_move_repeat_nxt = 1'b0;
          w_rr_ptr_nxt      = w_grant + 2'd1;
          w_timer_nxt       = '0;
        end else if (!w_active_held) begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
        end else if (r_timer == '0) begin
          w_state_nxt       = ST_ISSUE;
          w_move_valid_nxt  = 1'b1;
          w_move_repeat_nxt = 1'b1;
        end else begin
          w_timer_nxt = r_timer - CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt      = ST_IDLE;
        w_move_valid_nxt = 1'b0;
      end
    endcase
  end

  // State, timer and registered outputs.
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      r_rr_ptr      <= 2'd0;
      r_move_valid  <= 1'b0;
      r_move_dir    <= DIR_LEFT;
      r_move_repeat <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_timer       <= w_timer_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_move_valid  <= w_move_valid_nxt;
      r_move_dir    <= w_move_dir_nxt;
      r_move_repeat <= w_move_repeat_nxt;
      r_busy        <= (w_state_nxt != ST_IDLE);
    end
  end

  assign move_valid  = r_move_valid;
  assign move_dir    = r_move_dir;
  assign move_repeat = r_move_repeat;
  assign busy        = r_busy;

endmodule
